tm1638_key_reader: RTL
======================

Name: tm1638_key_reader

Overview:
Reads the TM1638 key-scan matrix. This is the read direction of the same 3-wire STB/CLK/DIO bus that the LED/segment writer drives.
- On a start request it issues the read-key command 0x42 LSB-first, releases DIO, and clocks in the 4 scan bytes.
- It presents the raw 32-bit scan plus a decoded 8-key vector.
- Top level arbitrates bus ownership between writer and reader using busy, and builds the DIO tri-state from dio_out/dio_oe/dio_in.

Parameters:
HALF_CYC, 1, clkinput cycles per half TM1638 clock period (>=1).
WAIT_CYC, 4, clkinput cycles between last command bit and first read clock (covers TM1638 Twait >= 2 us at 200 kHz clkinput with default).
DB_COUNT, 3, consecutive identical scans required before keys update (used only with TM1638_KEY_DEBOUNCE_EN).

Ports:
clkinput  in  1  block clock; all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  scan request, sampled in IDLE only.
busy  out  1  high from start acceptance until valid pulse inclusive.
stb  out  1  TM1638 STB, active low.
clk  out  1  TM1638 CLK.
dio_out  out  1  DIO drive value.
dio_oe  out  1  1 = drive DIO, 0 = release.
dio_in  in  1  DIO pad input.
scan_data  out  32  raw scan; byte n at [8n+7:8n], LSB received first.
keys  out  8  keys[i] = byte i bit0, keys[i+4] = byte i bit4 (i=0..3).
valid  out  1  one-cycle pulse when scan_data/keys updated.

Behaviour:
- Reset (async, rst_n low): immediately stb=1, clk=1, dio_oe=0, dio_out=0, busy=0, valid=0, scan_data=0, keys=0. FSM goes to IDLE. Any transfer in progress is abandoned with no partial update.
- FSM states: IDLE, SETUP, CMD, WAIT, READ, STOP, DONE.
- IDLE: stb=1, clk=1, dio_oe=0. start=1 at an edge moves to SETUP and sets busy=1. start in any other state is ignored, with no queueing.
- SETUP: stb=0, dio_oe=1, clk=1 for HALF_CYC cycles.
- CMD: 8 bits of 0x42, LSB first. Each bit is HALF_CYC cycles with clk=0 and dio_out=bit, then HALF_CYC cycles with clk=1 and dio_out held.
- WAIT: dio_oe=0, clk=1, stb=0 for WAIT_CYC cycles.
- READ: 32 bits. Each bit is HALF_CYC cycles clk=0, then HALF_CYC cycles clk=1.
  - dio_in is sampled at the edge that drives clk 0->1.
  - Sampled bits shift right into a 32-bit shift register, so the first bit lands at [0] after 32 shifts.
- STOP: stb=1, clk=1 for HALF_CYC cycles.
- DONE: scan_data <= shift register, keys updated, valid=1 for exactly one cycle, busy=0 next cycle, return to IDLE.
- Latency, start edge = edge 0: stb falls at edge 1. valid is high after edge 1 + 82*HALF_CYC + WAIT_CYC, i.e. edge 87 for the defaults.
- dio_oe never 1 while clk is being pulsed in READ. dio_oe drops at the same edge that enters WAIT.
- A start held high continuously produces back-to-back scans, with IDLE lasting >=1 cycle between them. stb-high time is therefore >= HALF_CYC+2 cycles.
- Counters: bit counter 5 bits, half-period counter sized by $clog2(max(HALF_CYC,WAIT_CYC)+1). No wrap beyond terminal counts.

Optional Feature:
Macro TM1638_KEY_DEBOUNCE_EN.
- Defined:
  - keys updates only when the decoded key vector equals the previous scan's vector for DB_COUNT consecutive scans.
  - A differing scan restarts the count at 1.
  - scan_data and valid still update every scan.
  - Reset clears the count and keys.
- Undefined: keys updates on every scan with no extra state.

Decomposition:
Shared package tm1638_pkg holds:
- TM1638_CMD_READ = 8'h42, TM1638_CMD_WRITE_AUTO = 8'h40, TM1638_CMD_ADDR0 = 8'hC0, TM1638_CMD_DISP_ON = 8'h8F;
- the state enum tm1638_rd_state_t;
- key-mapping function scan_to_keys.

One sub-module: tm1638_key_debounce, instantiated only under the macro.

Test Plan:
1. Reset mid-READ (assert rst_n low at edge 40) -> same cycle stb=1, clk=1, dio_oe=0; scan_data stays 0; no valid.
2. Defaults, pulse start -> stb low edge 1; bits seen on clk rising = 0,1,0,0,0,0,1,0 (0x42); exactly 8 clk pulses with dio_oe=1; valid at edge 87; busy high edges 1..87.
3. TM1638 model returns bytes 0x01, 0x10, 0x00, 0x11, changing DIO only while clk=0 -> scan_data=32'h11001001, keys=8'hA9, one valid pulse.
4. Check dio_oe=0 throughout WAIT and READ, and exactly 32 clk pulses during READ; a start pulse while busy -> ignored, with only one valid pulse.
5. start held high for 3 scans -> 3 valid pulses; stb high >= 3 cycles between transfers.
6. With TM1638_KEY_DEBOUNCE_EN and DB_COUNT=3, scans give keys 0x01, 0x01, 0x02, 0x02, 0x02 -> keys stays 0x00 until the 5th valid, then becomes 0x02.

Source files
------------

// File: rtl/tm1638_pkg.sv
// Shared TM1638 definitions: command bytes, key-reader state encoding and key-matrix mapping.
package tm1638_pkg;

    localparam logic [7:0] TM1638_CMD_READ       = 8'h42;
    localparam logic [7:0] TM1638_CMD_WRITE_AUTO = 8'h40;
    localparam logic [7:0] TM1638_CMD_ADDR0      = 8'hC0;
    localparam logic [7:0] TM1638_CMD_DISP_ON    = 8'h8F;

    typedef enum logic [2:0] {
        RD_IDLE  = 3'd0,
        RD_SETUP = 3'd1,
        RD_CMD   = 3'd2,
        RD_WAIT  = 3'd3,
        RD_READ  = 3'd4,
        RD_STOP  = 3'd5,
        RD_DONE  = 3'd6
    } tm1638_rd_state_t;

    // Keys K1..K4 live in bit0 of each scan byte, K5..K8 in bit4.
    function automatic logic [7:0] scan_to_keys(input logic [31:0] scan);
        logic [7:0] k;
        k = '0;
        for (int i = 0; i < 4; i++) begin
            k[i]     = scan[8*i];
            k[i + 4] = scan[8*i + 4];
        end
        return k;
    endfunction

endpackage

// File: rtl/tm1638_key_debounce.sv
// Holds the key vector until DB_COUNT consecutive identical scans have been seen.
module tm1638_key_debounce #(
    parameter int DB_COUNT = 3
) (
    input  logic       clkinput,
    input  logic       rst_n,
    input  logic       scan_stb,
    input  logic [7:0] keys_raw,
    output logic [7:0] keys
);

    localparam int              DB_W    = $clog2(DB_COUNT + 1);
    localparam logic [DB_W-1:0] DB_TERM = DB_W'(DB_COUNT);

    logic [DB_W-1:0] cnt_reg;
    logic [DB_W-1:0] cnt_next;
    logic [7:0]      prev_reg;
    logic [7:0]      keys_reg;

    // A zero count means no scan seen since reset, so the first scan always starts a run.
    always_comb begin
        cnt_next = cnt_reg;
        if (cnt_reg == '0 || keys_raw != prev_reg) begin
            cnt_next = DB_W'(1);
        end else if (cnt_reg != DB_TERM) begin
            cnt_next = cnt_reg + DB_W'(1);
        end
    end

    always_ff @(posedge clkinput or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg  <= '0;
            prev_reg <= '0;
            keys_reg <= '0;
        end else if (scan_stb) begin
            cnt_reg  <= cnt_next;
            prev_reg <= keys_raw;
            if (cnt_next == DB_TERM) begin
                keys_reg <= keys_raw;
            end
        end
    end

    assign keys = keys_reg;

endmodule

// File: rtl/tm1638_key_reader.sv
// TM1638 key-scan reader: sends 0x42, releases DIO and clocks in four scan bytes.
// Optional key debouncing is enabled by defining TM1638_KEY_DEBOUNCE_EN.
module tm1638_key_reader
    import tm1638_pkg::*;
#(
    parameter int HALF_CYC = 1,
    parameter int WAIT_CYC = 4,
    parameter int DB_COUNT = 3
) (
    input  logic        clkinput,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        stb,
    output logic        clk,
    output logic        dio_out,
    output logic        dio_oe,
    input  logic        dio_in,
    output logic [31:0] scan_data,
    output logic [7:0]  keys,
    output logic        valid
);

    localparam int               CNT_MAX   = (HALF_CYC > WAIT_CYC) ? HALF_CYC : WAIT_CYC;
    localparam int               CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYC - 1);

    localparam logic [2:0] S_IDLE  = RD_IDLE;
    localparam logic [2:0] S_SETUP = RD_SETUP;
    localparam logic [2:0] S_CMD   = RD_CMD;
    localparam logic [2:0] S_WAIT  = RD_WAIT;
    localparam logic [2:0] S_READ  = RD_READ;
    localparam logic [2:0] S_STOP  = RD_STOP;
    localparam logic [2:0] S_DONE  = RD_DONE;

    if (HALF_CYC < 1 || WAIT_CYC < 1 || DB_COUNT < 1) begin : g_bad_param
        $error("tm1638_key_reader: HALF_CYC, WAIT_CYC and DB_COUNT must all be >= 1");
    end

    logic [2:0]       state_reg;
    logic [CNT_W-1:0] half_cnt_reg;
    logic [4:0]       bit_cnt_reg;
    logic [31:0]      shift_reg;
    logic [31:0]      scan_data_reg;
    logic             stb_reg;
    logic             sclk_reg;
    logic             dio_out_reg;
    logic             dio_oe_reg;
    logic             busy_reg;
    logic             valid_reg;

    logic       half_done;
    logic       scan_done;
    logic [2:0] cmd_idx_next;
    logic [7:0] keys_raw;

    assign half_done    = (half_cnt_reg == '0);
    assign scan_done    = (state_reg == S_STOP) && half_done;
    assign cmd_idx_next = bit_cnt_reg[2:0] + 3'd1;
    assign keys_raw     = scan_to_keys(shift_reg);

    // Every bus output is a register, so reset forces the idle bus levels immediately.
    always_ff @(posedge clkinput or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            half_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            scan_data_reg <= '0;
            stb_reg       <= 1'b1;
            sclk_reg      <= 1'b1;
            dio_out_reg   <= 1'b0;
            dio_oe_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            valid_reg     <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            if (!half_done) begin
                half_cnt_reg <= half_cnt_reg - CNT_W'(1);
            end
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg    <= S_SETUP;
                        stb_reg      <= 1'b0;
                        dio_oe_reg   <= 1'b1;
                        dio_out_reg  <= 1'b0;
                        busy_reg     <= 1'b1;
                        half_cnt_reg <= HALF_LOAD;
                    end
                end
                S_SETUP: begin
                    if (half_done) begin
                        state_reg    <= S_CMD;
                        sclk_reg     <= 1'b0;
                        dio_out_reg  <= TM1638_CMD_READ[0];
                        bit_cnt_reg  <= '0;
                        half_cnt_reg <= HALF_LOAD;
                    end
                end
                S_CMD: begin
                    if (half_done) begin
                        if (!sclk_reg) begin
                            sclk_reg     <= 1'b1;
                            half_cnt_reg <= HALF_LOAD;
                        end else if (bit_cnt_reg == 5'd7) begin
                            state_reg    <= S_WAIT;
                            dio_oe_reg   <= 1'b0;
                            half_cnt_reg <= WAIT_LOAD;
                        end else begin
                            bit_cnt_reg  <= bit_cnt_reg + 5'd1;
                            sclk_reg     <= 1'b0;
                            dio_out_reg  <= TM1638_CMD_READ[cmd_idx_next];
                            half_cnt_reg <= HALF_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (half_done) begin
                        state_reg    <= S_READ;
                        sclk_reg     <= 1'b0;
                        bit_cnt_reg  <= '0;
                        half_cnt_reg <= HALF_LOAD;
                    end
                end
                S_READ: begin
                    // dio_in is captured on the same edge that raises clk.
                    if (half_done) begin
                        if (!sclk_reg) begin
                            sclk_reg     <= 1'b1;
                            shift_reg    <= {dio_in, shift_reg[31:1]};
                            half_cnt_reg <= HALF_LOAD;
                        end else if (bit_cnt_reg == 5'd31) begin
                            state_reg    <= S_STOP;
                            stb_reg      <= 1'b1;
                            half_cnt_reg <= HALF_LOAD;
                        end else begin
                            bit_cnt_reg  <= bit_cnt_reg + 5'd1;
                            sclk_reg     <= 1'b0;
                            half_cnt_reg <= HALF_LOAD;
                        end
                    end
                end
                S_STOP: begin
                    if (half_done) begin
                        state_reg     <= S_DONE;
                        scan_data_reg <= shift_reg;
                        valid_reg     <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

`ifdef TM1638_KEY_DEBOUNCE_EN
    tm1638_key_debounce #(
        .DB_COUNT (DB_COUNT)
    ) u_key_debounce (
        .clkinput (clkinput),
        .rst_n    (rst_n),
        .scan_stb (scan_done),
        .keys_raw (keys_raw),
        .keys     (keys)
    );
`else
    logic [7:0] keys_reg;

    always_ff @(posedge clkinput or negedge rst_n) begin
        if (!rst_n) begin
            keys_reg <= '0;
        end else if (scan_done) begin
            keys_reg <= keys_raw;
        end
    end

    assign keys = keys_reg;
`endif

    assign busy      = busy_reg;
    assign stb       = stb_reg;
    assign clk       = sclk_reg;
    assign dio_out   = dio_out_reg;
    assign dio_oe    = dio_oe_reg;
    assign scan_data = scan_data_reg;
    assign valid     = valid_reg;

endmodule
